// File: rtl/lsu_peripheral_responder.sv
// LSU-facing peripheral endpoint: round-robin arbitration of NUM_LSU ports onto one
// byte-enabled word store, returning grant-next-cycle, read-data-valid and write-accept.
module lsu_peripheral_responder #(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int NUM_LSU              = 1,
  parameter int DEPTH                = 256
) (
  input  logic                                       iClk,
  input  logic                                       iReset,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0]    iWriteAddress,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0]    iReadAddress,
  input  logic [NUM_LSU*(INTERFACE_WIDTH/8)-1:0]     iWriteEnable,
  input  logic [NUM_LSU*INTERFACE_WIDTH-1:0]         iWriteData,
  input  logic [NUM_LSU-1:0]                         iReadRequest,
  input  logic [NUM_LSU-1:0]                         iWriteRequest,
  output logic [NUM_LSU-1:0]                         oReadGrantNextCycle,
  output logic [NUM_LSU-1:0]                         oWriteGrantNextCycle,
  output logic [NUM_LSU*INTERFACE_WIDTH-1:0]         oReadData,
  output logic [NUM_LSU-1:0]                         oReadDataValid,
  output logic [NUM_LSU-1:0]                         oWriteAccept
);

  localparam int W      = INTERFACE_WIDTH;
  localparam int AW     = INTERFACE_ADDR_WIDTH;
  localparam int BYTES  = INTERFACE_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (NUM_LSU > 1) ? $clog2(NUM_LSU) : 1;

  // Handshake: a port holds its request until the cycle in which its grant bit is
  // high; the access happens at the end of that cycle only if the request is still
  // high then, and its valid/accept pulse follows one cycle later.

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_LSU-1:0] rd_gnt_q, rd_gnt_d;
  logic [NUM_LSU-1:0] wr_gnt_q, wr_gnt_d;
  logic [NUM_LSU-1:0] rd_vld_q, rd_vld_d;
  logic [NUM_LSU-1:0] wr_acc_q, wr_acc_d;
  logic [NUM_LSU*W-1:0] rd_data_q, rd_data_d;
  logic [W-1:0]       mem_q [DEPTH];

  logic [NUM_LSU-1:0] eligible;
  logic               arb_found;
  int                 arb_idx;

  logic               acc_wr;
  logic               acc_rd;
  int                 acc_port;
  logic [AW-1:0]      acc_addr;
  logic               acc_in_range;
  logic [IDX_W-1:0]   mem_idx;
  logic [W-1:0]       rd_word;
  logic [W-1:0]       wr_word;
  logic [BYTES-1:0]   acc_be;
  logic [W-1:0]       acc_wdata;
  logic               mem_we;

  // A port being served this cycle sits out one arbitration round.
  assign eligible = (iReadRequest | iWriteRequest) & ~(rd_gnt_q | wr_gnt_q);

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rd_gnt_d  = '0;
    wr_gnt_d  = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_LSU; i++) begin
      arb_idx = (int'(rr_ptr_q) + i) % NUM_LSU;
      if (!arb_found && eligible[arb_idx]) begin
        arb_found = 1'b1;
        if (iWriteRequest[arb_idx]) wr_gnt_d[arb_idx] = 1'b1;
        else                        rd_gnt_d[arb_idx] = 1'b1;
        rr_ptr_d = PTR_W'((arb_idx + 1) % NUM_LSU);
      end
    end
  end

  always_comb begin
    acc_wr   = 1'b0;
    acc_rd   = 1'b0;
    acc_port = 0;
    for (int p = 0; p < NUM_LSU; p++) begin
      if (wr_gnt_q[p] && iWriteRequest[p]) begin
        acc_wr   = 1'b1;
        acc_port = p;
      end
      if (rd_gnt_q[p] && iReadRequest[p]) begin
        acc_rd   = 1'b1;
        acc_port = p;
      end
    end
  end

  // Out-of-range addresses read as zero and never touch the store (no wrap).
  always_comb begin
    acc_addr     = acc_wr ? iWriteAddress[acc_port*AW +: AW] : iReadAddress[acc_port*AW +: AW];
    acc_in_range = acc_addr < AW'(DEPTH);
    mem_idx      = IDX_W'(acc_addr);
    rd_word      = acc_in_range ? mem_q[mem_idx] : '0;
    acc_be       = iWriteEnable[acc_port*BYTES +: BYTES];
    acc_wdata    = iWriteData[acc_port*W +: W];
    wr_word      = rd_word;
    for (int b = 0; b < BYTES; b++) begin
      if (acc_be[b]) wr_word[b*8 +: 8] = acc_wdata[b*8 +: 8];
    end
    mem_we = acc_wr && acc_in_range && iReset;
  end

  always_comb begin
    rd_vld_d  = '0;
    wr_acc_d  = '0;
    rd_data_d = rd_data_q;
    if (acc_rd) begin
      rd_vld_d[acc_port]          = 1'b1;
      rd_data_d[acc_port*W +: W]  = rd_word;
    end
    if (acc_wr) wr_acc_d[acc_port] = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      rr_ptr_q  <= '0;
      rd_gnt_q  <= '0;
      wr_gnt_q  <= '0;
      rd_vld_q  <= '0;
      wr_acc_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_vld_q  <= rd_vld_d;
      wr_acc_q  <= wr_acc_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Store is deliberately left out of reset.
  always_ff @(posedge iClk) begin
    if (mem_we) mem_q[mem_idx] <= wr_word;
  end

  assign oReadGrantNextCycle  = rd_gnt_q;
  assign oWriteGrantNextCycle = wr_gnt_q;
  assign oReadData            = rd_data_q;
  assign oReadDataValid       = rd_vld_q;
  assign oWriteAccept         = wr_acc_q;

endmodule

// File: tb/tb_lsu_peripheral_responder.sv
// Directed bench for lsu_peripheral_responder (two ports, 16-word store): the driver
// pushes timed grant/response expectations, a negedge monitor pops and compares them.
module tb_lsu_peripheral_responder;

  localparam int W     = 32;
  localparam int AW    = 32;
  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int BY    = W / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N*AW-1:0] wr_addr;
  logic [N*AW-1:0] rd_addr;
  logic [N*BY-1:0] we;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    rd_req;
  logic [N-1:0]    wr_req;
  logic [N-1:0]    rg;
  logic [N-1:0]    wg;
  logic [N-1:0]    rv;
  logic [N-1:0]    wa;
  logic [N*W-1:0]  rdata;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // {cycle[15:0], port, kind(1=write), data[31:0]}
  logic [49:0] exp_q[$];
  // {cycle[15:0], port, kind(1=write)}
  logic [17:0] gnt_q[$];
  logic [49:0] act_rsp;
  logic [49:0] exp_rsp;
  logic [17:0] act_gnt;
  logic [17:0] exp_gnt;

  lsu_peripheral_responder #(
    .INTERFACE_WIDTH      (W),
    .INTERFACE_ADDR_WIDTH (AW),
    .NUM_LSU              (N),
    .DEPTH                (DEPTH)
  ) dut (
    .iClk                 (clk),
    .iReset               (rst_n),
    .iWriteAddress        (wr_addr),
    .iReadAddress         (rd_addr),
    .iWriteEnable         (we),
    .iWriteData           (wdata),
    .iReadRequest         (rd_req),
    .iWriteRequest        (wr_req),
    .oReadGrantNextCycle  (rg),
    .oWriteGrantNextCycle (wg),
    .oReadData            (rdata),
    .oReadDataValid       (rv),
    .oWriteAccept         (wa)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rd(input int p, input logic req, input logic [AW-1:0] addr);
    rd_req[p]            = req;
    rd_addr[p*AW +: AW]  = addr;
  endtask

  task automatic drive_wr(input int p, input logic req, input logic [AW-1:0] addr,
                          input logic [BY-1:0] en, input logic [W-1:0] d);
    wr_req[p]            = req;
    wr_addr[p*AW +: AW]  = addr;
    we[p*BY +: BY]       = en;
    wdata[p*W +: W]      = d;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) begin
      drive_rd(p, 1'b0, '0);
      drive_wr(p, 1'b0, '0, '0, '0);
    end
  endtask

  task automatic push_gnt(input int c, input int p, input logic kind);
    gnt_q.push_back({16'(c), 1'(p), kind});
  endtask

  task automatic push_rsp(input int c, input int p, input logic kind, input logic [W-1:0] d);
    exp_q.push_back({16'(c), 1'(p), kind, d});
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] addr, input logic [BY-1:0] en,
                          input logic [W-1:0] d);
    drive_wr(p, 1'b1, addr, en, d);
    push_gnt(cyc + 1, p, 1'b1);
    push_rsp(cyc + 2, p, 1'b1, '0);
    step();
    step();
    drive_wr(p, 1'b0, addr, en, d);
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] addr, input logic [W-1:0] expd);
    drive_rd(p, 1'b1, addr);
    push_gnt(cyc + 1, p, 1'b0);
    push_rsp(cyc + 2, p, 1'b0, expd);
    step();
    step();
    drive_rd(p, 1'b0, addr);
  endtask

  task automatic check_idle();
    @(negedge clk);
    checks++;
    if ({rg, wg, rv, wa, rdata} !== '0) begin
      failures++;
      $display("FAIL idle_outputs cycle=%0d got rg=%b wg=%b rv=%b wa=%b rdata=%h want all 0",
               cyc, rg, wg, rv, wa, rdata);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    while (gnt_q.size() > 0 && int'(gnt_q[0][17:2]) < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_grant cycle=%0d got none want %h", cyc, gnt_q[0]);
      void'(gnt_q.pop_front());
    end
    while (exp_q.size() > 0 && int'(exp_q[0][49:34]) < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_response cycle=%0d got none want %h", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (|(rg | wg)) begin
      checks++;
      if ($countones(rg | wg) != 1) begin
        failures++;
        $display("FAIL one_grant cycle=%0d got rg=%b wg=%b want one bit", cyc, rg, wg);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (rg[p] || wg[p]) begin
        act_gnt = {16'(cyc), 1'(p), wg[p]};
        checks++;
        if (gnt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant got %h want none", act_gnt);
        end else begin
          exp_gnt = gnt_q.pop_front();
          if (act_gnt !== exp_gnt) begin
            failures++;
            $display("FAIL grant got %h want %h", act_gnt, exp_gnt);
          end
        end
      end
      if (rv[p] || wa[p]) begin
        act_rsp = {16'(cyc), 1'(p), wa[p], wa[p] ? 32'h0 : rdata[p*W +: W]};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_response got %h want none", act_rsp);
        end else begin
          exp_rsp = exp_q.pop_front();
          if (act_rsp !== exp_rsp) begin
            failures++;
            $display("FAIL response got %h want %h", act_rsp, exp_rsp);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int t;
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; we = '0; wdata = '0;

    // Reset held with every request high; store-neutral writes (no byte enables).
    for (int p = 0; p < N; p++) begin
      drive_rd(p, 1'b1, '0);
      drive_wr(p, 1'b1, 32'd15, '0, 32'hFFFF_FFFF);
    end
    repeat (3) begin
      step();
      check_idle();
    end
    step();
    rst_n = 1'b1;
    push_gnt(cyc + 1, 0, 1'b1);   // pointer reset to 0, write beats read
    check_idle();
    step();
    clear_all();                  // dropped in its grant cycle: no accept
    step();

    // Single-port write / read and byte-enable merge.
    do_write(0, 32'd5, 4'hF, 32'hDEAD_BEEF);
    do_read(0, 32'd5, 32'hDEAD_BEEF);
    do_write(0, 32'd5, 4'b0101, 32'h1122_3344);
    do_read(0, 32'd5, 32'hDE22_BE44);
    do_write(1, 32'd6, 4'hF, 32'hCAFE_F00D);   // leaves pointer at 0

    // Both ports reading continuously: alternating grants, last grant cancelled.
    drive_rd(0, 1'b1, 32'd5);
    drive_rd(1, 1'b1, 32'd6);
    t = cyc;
    for (int i = 0; i < 7; i++) push_gnt(t + 1 + i, i % 2, 1'b0);
    for (int i = 0; i < 6; i++)
      push_rsp(t + 2 + i, i % 2, 1'b0, (i % 2 == 1) ? 32'hCAFE_F00D : 32'hDE22_BE44);
    repeat (7) step();
    clear_all();
    step();

    // Pointer is at 1: port 1 write then port 0 read of the same word.
    drive_wr(1, 1'b1, 32'd9, 4'hF, 32'h600D_CAFE);
    drive_rd(0, 1'b1, 32'd9);
    t = cyc;
    push_gnt(t + 1, 1, 1'b1);
    push_rsp(t + 2, 1, 1'b1, '0);
    push_gnt(t + 2, 0, 1'b0);
    push_rsp(t + 3, 0, 1'b0, 32'h600D_CAFE);
    step();
    step();
    drive_wr(1, 1'b0, 32'd9, 4'hF, 32'h600D_CAFE);
    step();
    drive_rd(0, 1'b0, 32'd9);

    // Read and write together on one port: write first, read after the masked cycle.
    drive_wr(0, 1'b1, 32'd7, 4'hF, 32'h0A0B_0C0D);
    drive_rd(0, 1'b1, 32'd7);
    t = cyc;
    push_gnt(t + 1, 0, 1'b1);
    push_rsp(t + 2, 0, 1'b1, '0);
    push_gnt(t + 3, 0, 1'b0);
    push_rsp(t + 4, 0, 1'b0, 32'h0A0B_0C0D);
    step();
    step();
    drive_wr(0, 1'b0, 32'd7, 4'hF, 32'h0A0B_0C0D);
    step();
    step();
    drive_rd(0, 1'b0, 32'd7);

    // Write and read dropped in their grant cycles.
    drive_wr(0, 1'b1, 32'd7, 4'hF, 32'hFFFF_FFFF);
    push_gnt(cyc + 1, 0, 1'b1);
    step();
    drive_wr(0, 1'b0, 32'd7, 4'hF, 32'hFFFF_FFFF);
    step();
    drive_rd(1, 1'b1, 32'd7);
    push_gnt(cyc + 1, 1, 1'b0);
    step();
    drive_rd(1, 1'b0, 32'd7);
    step();
    do_read(0, 32'd7, 32'h0A0B_0C0D);

    // Out-of-range accesses: accepted/valid, store untouched, no wrap-around.
    do_write(0, 32'd0, 4'hF, 32'h55AA_55AA);
    do_write(0, 32'd16, 4'hF, 32'h1234_5678);
    do_read(0, 32'd16, 32'h0);
    do_read(0, 32'd0, 32'h55AA_55AA);
    do_read(1, 32'h100, 32'h0);

    // Reset asserted in the grant cycle cancels the write.
    drive_wr(0, 1'b1, 32'd0, 4'hF, 32'h0);
    push_gnt(cyc + 1, 0, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_wr(0, 1'b0, 32'd0, 4'hF, 32'h0);
    step();
    do_read(0, 32'd0, 32'h55AA_55AA);

    repeat (4) step();
    @(negedge clk);
    checks++;
    if (gnt_q.size() != 0) begin
      failures++;
      $display("FAIL grant_queue_drained got %0d left want 0", gnt_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL response_queue_drained got %0d left want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
